// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type encodings and bus layouts for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int EM_BUS_W  = 106;
  localparam int MW_BUS_W  = 102;
  localparam int WR_BUS_W  = 6;
  localparam int FWD_BUS_W = 39;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  typedef struct packed {
    logic [2:0]  ld_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] inst;
  } em_bus_t;

  typedef struct packed {
    logic [31:0] final_result;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
  } mw_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: combinational byte/halfword select and sign/zero extension of load data.
// Codes 5-7 and ld.w return the full word; low address bits are ignored for word access.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_sel,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_sel[7:0];
    case (addr)
      2'd1:    byte_sel = rdata_sel[15:8];
      2'd2:    byte_sel = rdata_sel[23:16];
      2'd3:    byte_sel = rdata_sel[31:24];
      default: byte_sel = rdata_sel[7:0];
    endcase
    half_sel = addr[1] ? rdata_sel[31:16] : rdata_sel[15:0];

    load_data = rdata_sel;
    case (ld_type)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_BU:   load_data = {24'd0, byte_sel};
      LD_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata_sel;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; 1 cycle accept-to-valid, stalls on WB_allow_in=0 keeping load data stable.
// Define MEM_STAGE_FWD_EN to add MEM_fwd_bus (forwarding and load-use info for ID).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                EXE_to_MEM_valid,
  input  logic [EM_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                MEM_allow_in,
  input  logic [31:0]         data_sram_rdata,
  output logic                MEM_to_WB_valid,
  output logic [MW_BUS_W-1:0] MEM_to_WB_bus,
  input  logic                WB_allow_in,
  output logic [WR_BUS_W-1:0] MEM_wr_bus
`ifdef MEM_STAGE_FWD_EN
  ,
  output logic [FWD_BUS_W-1:0] MEM_fwd_bus
`endif
);

  logic        mem_valid_q, mem_valid_d;
  logic        first_cycle_q, first_cycle_d;
  em_bus_t     payload_q, payload_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;

  logic        mem_ready_go;
  logic        accept;
  logic [31:0] rdata_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;
  mw_bus_t     mw_bus;

  always_comb begin
    mem_ready_go  = 1'b1;
    MEM_allow_in  = ~mem_valid_q | (mem_ready_go & WB_allow_in);
    accept        = EXE_to_MEM_valid & MEM_allow_in;

    mem_valid_d   = MEM_allow_in ? EXE_to_MEM_valid : mem_valid_q;
    payload_d     = accept ? em_bus_t'(EXE_to_MEM_bus) : payload_q;
    first_cycle_d = accept;
    // SRAM data is only valid in the first cycle; afterwards the captured copy is used.
    rdata_hold_d  = first_cycle_q ? data_sram_rdata : rdata_hold_q;
    rdata_sel     = rdata_hold_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q   <= 1'b0;
      first_cycle_q <= 1'b0;
      payload_q     <= '0;
      rdata_hold_q  <= 32'd0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      first_cycle_q <= first_cycle_d;
      payload_q     <= payload_d;
      rdata_hold_q  <= rdata_hold_d;
    end
  end

  mem_load_align u_load_align (
    .rdata_sel (rdata_sel),
    .addr      (payload_q.alu_result[1:0]),
    .ld_type   (payload_q.ld_type),
    .load_data (load_data)
  );

  always_comb begin
    final_result        = payload_q.res_from_mem ? load_data : payload_q.alu_result;
    mw_bus.final_result = final_result;
    mw_bus.gr_we        = payload_q.gr_we;
    mw_bus.dest         = payload_q.dest;
    mw_bus.pc           = payload_q.pc;
    mw_bus.inst         = payload_q.inst;

    MEM_to_WB_valid = mem_valid_q & mem_ready_go;
    MEM_to_WB_bus   = mw_bus;
    MEM_wr_bus      = {payload_q.gr_we & mem_valid_q, payload_q.dest};
  end

`ifdef MEM_STAGE_FWD_EN
  assign MEM_fwd_bus = {mem_valid_q & payload_q.gr_we, mem_valid_q & payload_q.res_from_mem,
                        payload_q.dest, final_result};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps followed by randomized traffic against a reference model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         EXE_to_MEM_valid;
  logic [105:0] EXE_to_MEM_bus;
  logic         MEM_allow_in;
  logic [31:0]  data_sram_rdata;
  logic         MEM_to_WB_valid;
  logic [101:0] MEM_to_WB_bus;
  logic         WB_allow_in;
  logic [5:0]   MEM_wr_bus;
`ifdef MEM_STAGE_FWD_EN
  logic [38:0]  MEM_fwd_bus;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .EXE_to_MEM_valid (EXE_to_MEM_valid),
    .EXE_to_MEM_bus   (EXE_to_MEM_bus),
    .MEM_allow_in     (MEM_allow_in),
    .data_sram_rdata  (data_sram_rdata),
    .MEM_to_WB_valid  (MEM_to_WB_valid),
    .MEM_to_WB_bus    (MEM_to_WB_bus),
    .WB_allow_in      (WB_allow_in),
    .MEM_wr_bus       (MEM_wr_bus)
`ifdef MEM_STAGE_FWD_EN
    ,
    .MEM_fwd_bus      (MEM_fwd_bus)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction currently held, whether it arrived last edge,
  // and the memory word seen on its first cycle.
  bit           m_valid;
  bit           m_first;
  logic [105:0] m_pl;
  logic [31:0]  m_word;

  task automatic chk(input string tag, input logic [101:0] obs, input logic [101:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'd1:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd3:    return b;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [105:0] mk(input logic [2:0] lt, input logic rfm, input logic we,
                                      input logic [4:0] dst, input logic [31:0] alu,
                                      input logic [31:0] pc, input logic [31:0] inst);
    return {lt, rfm, we, dst, alu, pc, inst};
  endfunction

  function automatic logic [105:0] rand_bus();
    return mk(3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              5'($urandom_range(31)), $urandom, $urandom, $urandom);
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_first = 0;
    m_pl    = '0;
    m_word  = 32'd0;
  endtask

  // Called at posedge+1; leaves time at posedge+2 with inputs applied.
  task automatic drive(input logic ev, input logic [105:0] bus, input logic [31:0] rd, input logic wa);
    EXE_to_MEM_valid = ev;
    EXE_to_MEM_bus   = bus;
    data_sram_rdata  = rd;
    WB_allow_in      = wa;
    #1;
  endtask

  function automatic logic [31:0] model_final();
    logic [31:0] word;
    word = m_first ? data_sram_rdata : m_word;
    return m_pl[102] ? ref_load(word, m_pl[65:64], m_pl[105:103]) : m_pl[95:64];
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] fin;
    fin = model_final();
    chk({tag, ".allow_in"}, MEM_allow_in, !m_valid || WB_allow_in);
    chk({tag, ".wb_valid"}, MEM_to_WB_valid, m_valid);
    chk({tag, ".wb_bus"}, MEM_to_WB_bus, {fin, m_pl[101], m_pl[100:96], m_pl[63:32], m_pl[31:0]});
    chk({tag, ".wr_bus"}, MEM_wr_bus, {m_pl[101] && m_valid, m_pl[100:96]});
`ifdef MEM_STAGE_FWD_EN
    chk({tag, ".fwd_bus"}, MEM_fwd_bus, {m_pl[101] && m_valid, m_pl[102] && m_valid, m_pl[100:96], fin});
`endif
  endtask

  task automatic tick();
    bool_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bool_step();
    bit can_take;
    can_take = !m_valid || WB_allow_in;
    if (m_first) m_word = data_sram_rdata;
    m_first = can_take && EXE_to_MEM_valid;
    if (can_take && EXE_to_MEM_valid) m_pl = EXE_to_MEM_bus;
    if (can_take) m_valid = EXE_to_MEM_valid;
  endtask

  logic [2:0]  lt_tab [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
  logic [31:0] ad_tab [4] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0002};
  logic [31:0] rd_tab [4] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_1234};
  logic [31:0] ex_tab [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
  logic [31:0] pc_q [$];

  initial begin
    resetn = 1'b1;
    EXE_to_MEM_valid = 1'b0;
    EXE_to_MEM_bus = '0;
    data_sram_rdata = 32'd0;
    WB_allow_in = 1'b1;
    model_reset();

    // Reset asserted mid-cycle after one accepted instruction
    @(posedge clk); #1;
    drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd9, 32'hA5A5_0000, 32'h4, 32'h8), 32'd0, 1'b1);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("reset.wb_valid", MEM_to_WB_valid, 1'b0);
    chk("reset.wr_bus", MEM_wr_bus, 6'h00);
    chk("reset.wb_bus", MEM_to_WB_bus, 102'd0);
    drive(1'b0, '0, 32'd0, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, rand_bus(), $urandom, 1'b1);
      check_model("idle");
      tick();
    end

    // ALU pass-through
    drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0000, 32'h0280_0000), 32'hDEAD_0000, 1'b1);
    check_model("alu.accept");
    tick();
    drive(1'b0, '0, $urandom, 1'b1);
    check_model("alu.out");
    chk("alu.final", MEM_to_WB_bus[101:70], 32'h1234_5678);
    chk("alu.valid", MEM_to_WB_valid, 1'b1);
    chk("alu.wr_bus", MEM_wr_bus, 6'h25);
    tick();

    // Byte / halfword extraction
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(lt_tab[i], 1'b1, 1'b1, 5'd7, ad_tab[i], 32'h100 + 32'(i), 32'h0), 32'd0, 1'b1);
      check_model("ld.accept");
      tick();
      drive(1'b0, '0, rd_tab[i], 1'b1);
      check_model("ld.out");
      chk("ld.final", MEM_to_WB_bus[101:70], ex_tab[i]);
      tick();
    end

    // Back-pressure: load data and payload must hold while WB stalls
    drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd3, 32'h2000_0000, 32'hBEEF_0000, 32'h1), 32'd0, 1'b1);
    check_model("bp.accept");
    tick();
    drive(1'b1, rand_bus(), 32'hCAFE_BABE, 1'b0);
    check_model("bp.first");
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_bus(), 32'h0, 1'b0);
      check_model("bp.stall");
      chk("bp.final", MEM_to_WB_bus[101:70], 32'hCAFE_BABE);
      chk("bp.allow_in", MEM_allow_in, 1'b0);
      chk("bp.pc", MEM_to_WB_bus[63:32], 32'hBEEF_0000);
      tick();
    end
    drive(1'b0, '0, 32'h0, 1'b1);
    check_model("bp.drain");
    tick();
    drive(1'b0, '0, 32'h0, 1'b1);
    check_model("bp.empty");
    chk("bp.wr_vld", MEM_wr_bus[5], 1'b0);
    tick();

    // Back-to-back stream of four, alternating ALU and load entries
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        pc_q.push_back(32'h3000 + 32'(4 * k));
        drive(1'b1, mk(3'd0, 1'(k % 2), 1'b1, 5'(k + 1), $urandom, 32'h3000 + 32'(4 * k), $urandom), $urandom, 1'b1);
      end else begin
        drive(1'b0, '0, $urandom, 1'b1);
      end
      check_model("stream");
      if (k > 0) begin
        chk("stream.valid", MEM_to_WB_valid, 1'b1);
        chk("stream.pc", MEM_to_WB_bus[63:32], pc_q.pop_front());
`ifdef MEM_STAGE_FWD_EN
        chk("stream.fwd_load", MEM_fwd_bus[37], 1'((k - 1) % 2));
`endif
      end
      tick();
    end

    // Randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(3) != 0), rand_bus(), $urandom, 1'($urandom_range(3) != 0));
      check_model("rand");
      if (i == 200) begin
        resetn = 1'b0;
        #1;
        model_reset();
        chk("rand.reset_valid", MEM_to_WB_valid, 1'b0);
        chk("rand.reset_bus", MEM_to_WB_bus, 102'd0);
        resetn = 1'b1;
        #1;
        check_model("rand.after_reset");
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the 5-stage CPU, between EXE and WB.
- Latches the EXE→MEM payload under valid/allow_in handshake.
- Captures synchronous data-SRAM read data, sign/zero-extends and aligns loads, and drives the 102-bit MEM→WB bus consumed by the write-back stage.
- Publishes destination info to ID for hazard detection.

Parameters:
- EM_BUS_W, 106, width of EXE→MEM bus.
- MW_BUS_W, 102, width of MEM→WB bus.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- EXE_to_MEM_valid  in  1  EXE holds a valid instruction for MEM.
- EXE_to_MEM_bus  in  106  {ld_type[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0], inst[31:0]}, MSB first.
- MEM_allow_in  out  1  MEM can accept this cycle.
- data_sram_rdata  in  32  SRAM read data; valid only in the first cycle an instruction occupies MEM.
- MEM_to_WB_valid  out  1  MEM output valid.
- MEM_to_WB_bus  out  102  {final_result[31:0], gr_we, dest[4:0], pc[31:0], inst[31:0]}, MSB first.
- WB_allow_in  in  1  WB can accept.
- MEM_wr_bus  out  6  {gr_we & MEM_valid, dest} for ID hazard check.

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low:
  - MEM_valid, first_cycle, payload register and rdata_hold all clear to 0.
  - Result: MEM_to_WB_valid=0, MEM_to_WB_bus=0, MEM_wr_bus=0.
- Handshake:
  - MEM_ready_go=1.
  - MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- Acceptance:
  - When MEM_allow_in, MEM_valid <= EXE_to_MEM_valid.
  - Payload is loaded only when EXE_to_MEM_valid & MEM_allow_in; otherwise it holds.
- first_cycle:
  - Set to 1 on every accept; cleared the following cycle.
  - When first_cycle=1, rdata_hold <= data_sram_rdata.
  - Selected rdata: rdata_sel = first_cycle ? data_sram_rdata : rdata_hold.
  - This keeps load data stable while WB back-pressures (WB_allow_in=0) for any number of cycles.
- Load extraction uses addr[1:0]=alu_result[1:0]:
  - ld_type 0 ld.w: full word.
  - ld_type 1 ld.b: byte at addr[1:0], sign-extended.
  - ld_type 2 ld.h: halfword at addr[1], sign-extended.
  - ld_type 3 ld.bu: byte, zero-extended.
  - ld_type 4 ld.hu: halfword, zero-extended.
  - ld_type 5–7: treated as ld.w.
  - Misaligned ld.w / ld.h are not checked; the low address bits are ignored.
- Result select: final_result = res_from_mem ? load_data : alu_result.
- MEM_to_WB_bus fields pass through from the payload register unchanged.
- Latency: 1 cycle from accept to MEM_to_WB_valid.
- Back-to-back: full throughput when WB_allow_in=1.
- Simultaneous drain and fill: the new payload replaces the old in the same edge.
- EXE_to_MEM_valid=0 while MEM drains: MEM_valid goes to 0, and MEM_wr_bus[5] drops to 0 the same cycle.
- Reset asserted mid-stall: valid clears immediately (async), and the held rdata is discarded.

Optional Feature:
- Macro: MEM_STAGE_FWD_EN.
- When defined:
  - Adds output port MEM_fwd_bus, out, 39 bits: {MEM_valid & gr_we, MEM_valid & res_from_mem, dest[4:0], final_result[31:0]}.
  - ID uses it to forward ALU results and to identify load-use stalls.
- When undefined: port absent; only MEM_wr_bus is provided.
- Core handshake and timing are identical in both builds.

Decomposition:
- Shared package: bus widths (EM_BUS_W, MW_BUS_W, WR_BUS_W=6, FWD_BUS_W=39) and ld_type encodings (LD_W=0, LD_B=1, LD_H=2, LD_BU=3, LD_HU=4).
- One natural sub-module: mem_load_align, purely combinational; inputs rdata_sel, addr[1:0], ld_type; output load_data.

Test Plan:
- Reset and idle: resetn=0 asynchronously mid-cycle → MEM_to_WB_valid=0, MEM_wr_bus=6'h00 immediately. Release with no input → stays idle.
- ALU pass-through: accept gr_we=1, dest=5, alu_result=32'h1234_5678, res_from_mem=0 → next cycle MEM_to_WB_valid=1, final_result=32'h1234_5678, MEM_wr_bus=6'h25.
- ld.b sign: addr low bits 2'b11, rdata=32'h80FF_0000 → final_result=32'hFFFF_FF80. The same access as ld.bu → 32'h0000_0080.
- ld.h / ld.hu: addr[1]=1, rdata=32'h8001_1234 → final_result=32'hFFFF_8001 and 32'h0000_8001 respectively.
- Back-pressure hold: ld.w accepted with rdata=32'hCAFE_BABE, then rdata changes to 32'h0 while WB_allow_in=0 for 3 cycles → final_result stays 32'hCAFE_BABE, MEM_allow_in=0, and the payload is unchanged despite new EXE input.
- Back-to-back stream: 4 consecutive accepts with WB_allow_in=1 → 4 consecutive valid WB cycles, in order, no bubbles. With MEM_STAGE_FWD_EN defined, MEM_fwd_bus[37] is 1 only for the load entries.
